// File: rtl/sweep_pkg.sv
// Shared types and helpers for the exhaustive vector sweeper.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        CHECK,
        DONE
    } sweep_state_e;

    localparam int HOLD_CYCLES_MIN = 2;

    function automatic int num_vec(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/sweep_vec_counter.sv
// Hold and vector counters for the sweeper: steps through vectors 0..NUM_VEC-1,
// flagging the last hold cycle of a vector and the last vector of a sweep.
module sweep_vec_counter
    import sweep_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            hold_en,
    input  logic            advance,
    output logic [N_IN-1:0] vec,
    output logic            last_hold,
    output logic            last_vec
);

    // Values below the minimum are clamped so the HOLD state always lasts at least one cycle.
    localparam int HOLD_EFF = (HOLD_CYCLES < HOLD_CYCLES_MIN) ? HOLD_CYCLES_MIN : HOLD_CYCLES;
    localparam int HW       = (HOLD_EFF > 2) ? $clog2(HOLD_EFF) : 1;

    logic [HW-1:0]   hold_q, hold_d;
    logic [N_IN-1:0] vec_q, vec_d;

    assign vec       = vec_q;
    assign last_hold = (hold_q == HW'(HOLD_EFF - 2));
    assign last_vec  = (vec_q == {N_IN{1'b1}});

    always_comb begin
        hold_d = hold_q;
        vec_d  = vec_q;
        if (clear) begin
            hold_d = '0;
            vec_d  = '0;
        end else if (advance) begin
            hold_d = '0;
            vec_d  = vec_q + 1'b1;
        end else if (hold_en && !last_hold) begin
            hold_d = hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            vec_q  <= '0;
        end else begin
            hold_q <= hold_d;
            vec_q  <= vec_d;
        end
    end

endmodule

// File: rtl/exhaustive_vector_sweeper.sv
// Walks all 2^N_IN input vectors, compares the DUT output with a latched truth table
// and reports statistics. Define SWEEP_STOP_ON_FAIL_EN to halt on the first mismatch.
module exhaustive_vector_sweeper
    import sweep_pkg::*;
#(
    parameter int  N_IN        = 4,
    parameter int  HOLD_CYCLES = 2,
    localparam int NUM_VEC     = num_vec(N_IN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NUM_VEC-1:0] expected_tt,
    input  logic               dut_out,
    output logic [N_IN-1:0]    dut_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [N_IN:0]      err_count,
    output logic [N_IN-1:0]    first_fail_vec
);

    sweep_state_e       state_q, state_d;
    logic [NUM_VEC-1:0] tt_q, tt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [N_IN:0]      err_q, err_d;
    logic [N_IN-1:0]    ffv_q, ffv_d;

    logic            clear, hold_en, advance, finish, mismatch;
    logic [N_IN-1:0] vec;
    logic            last_hold, last_vec;

    sweep_vec_counter #(
        .N_IN        (N_IN),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .hold_en   (hold_en),
        .advance   (advance),
        .vec       (vec),
        .last_hold (last_hold),
        .last_vec  (last_vec)
    );

    // Case inequality so an X/Z output from the block under test counts as a failure.
    assign mismatch = (dut_out !== tt_q[vec]);

    always_comb begin
        state_d = state_q;
        tt_d    = tt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        clear   = 1'b0;
        hold_en = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    tt_d    = expected_tt;
                    err_d   = '0;
                    ffv_d   = '0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    clear   = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                hold_en = 1'b1;
                if (last_hold) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        ffv_d = vec;
                    end
                end
                finish = last_vec;
`ifdef SWEEP_STOP_ON_FAIL_EN
                finish = finish | mismatch;
`endif
                if (finish) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    advance = 1'b1;
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ffv_q   <= '0;
        end else begin
            state_q <= state_d;
            tt_q    <= tt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
        end
    end

    assign dut_in         = vec;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: tb/tb_exhaustive_vector_sweeper.sv
// Scoreboard bench for the sweeper: a 4-input XOR instance and a 2-input AND instance,
// each with an injectable fault mask; expected sweep results are modelled in plain loops.
module tb_exhaustive_vector_sweeper;

    typedef struct {
        int passExp;
        int errExp;
        int ffvExp;
        int lastVec;
        int cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        startA = 1'b0;
    logic [15:0] ttA    = '0;
    logic [15:0] faultA = '0;
    logic        dutOutA;
    logic [3:0]  dutInA;
    logic        busyA, doneA, passA;
    logic [4:0]  errA;
    logic [3:0]  ffvA;

    logic        startB = 1'b0;
    logic [3:0]  ttB    = '0;
    logic [3:0]  faultB = '0;
    logic        dutOutB;
    logic [1:0]  dutInB;
    logic        busyB, doneB, passB;
    logic [2:0]  errB;
    logic [1:0]  ffvB;

    int   checks = 0;
    int   errors = 0;
    exp_t qA[$];
    exp_t qB[$];
    int   busyCntA = 0, busyCntB = 0;
    logic donePrevA = 1'b0, donePrevB = 1'b0;

    always #5 clk = ~clk;

    assign dutOutA = (^dutInA) ^ faultA[dutInA];
    assign dutOutB = (&dutInB) ^ faultB[dutInB];

    exhaustive_vector_sweeper #(.N_IN(4), .HOLD_CYCLES(2)) dutA (
        .clk(clk), .rst(rst), .start(startA), .expected_tt(ttA), .dut_out(dutOutA),
        .dut_in(dutInA), .busy(busyA), .done(doneA), .pass(passA),
        .err_count(errA), .first_fail_vec(ffvA)
    );

    exhaustive_vector_sweeper #(.N_IN(2), .HOLD_CYCLES(3)) dutB (
        .clk(clk), .rst(rst), .start(startB), .expected_tt(ttB), .dut_out(dutOutB),
        .dut_in(dutInB), .busy(busyB), .done(doneB), .pass(passB),
        .err_count(errB), .first_fail_vec(ffvB)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: evaluate the intended function per vector, count disagreements with the table.
    function automatic exp_t modelSweep(input int nIn, input int hold, input logic [255:0] tt,
                                        input logic [255:0] fault, input bit isAnd);
        exp_t e;
        int   nv = 1 << nIn;
        bit   f;
        e.errExp  = 0;
        e.ffvExp  = 0;
        e.lastVec = nv - 1;
        e.cycles  = nv * hold;
        for (int v = 0; v < nv; v++) begin
            f = isAnd ? (v == nv - 1) : ($countones(v) % 2 == 1);
            f = f ^ fault[v];
            if (f != tt[v]) begin
                if (e.errExp == 0) e.ffvExp = v;
                e.errExp++;
`ifdef SWEEP_STOP_ON_FAIL_EN
                e.lastVec = v;
                e.cycles  = (v + 1) * hold;
                break;
`endif
            end
        end
        e.passExp = (e.errExp == 0);
        return e;
    endfunction

    task automatic waitDoneA();
        int n = 0;
        while (!doneA && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("doneReachedA", int'(doneA), 1);
        @(negedge clk);
    endtask

    task automatic waitDoneB();
        int n = 0;
        while (!doneB && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("doneReachedB", int'(doneB), 1);
        @(negedge clk);
    endtask

    task automatic applyStimulusA(input logic [15:0] tt, input logic [15:0] fault, input bit poke);
        qA.push_back(modelSweep(4, 2, tt, fault, 1'b0));
        @(negedge clk);
        faultA = fault;
        ttA    = tt;
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        ttA    = ~tt ^ 16'($urandom);
        checkOutput("busyAfterStartA", int'(busyA), 1);
        checkOutput("doneAfterStartA", int'(doneA), 0);
        if (poke) begin
            repeat (6) @(negedge clk);
            startA = 1'b1;
            ttA    = 16'h0000;
            @(negedge clk);
            startA = 1'b0;
        end
        waitDoneA();
    endtask

    task automatic applyStimulusB(input logic [3:0] tt, input logic [3:0] fault);
        qB.push_back(modelSweep(2, 3, {252'd0, tt}, {252'd0, fault}, 1'b1));
        @(negedge clk);
        faultB = fault;
        ttB    = tt;
        startB = 1'b1;
        @(negedge clk);
        startB = 1'b0;
        ttB    = 4'($urandom);
        checkOutput("busyAfterStartB", int'(busyB), 1);
        checkOutput("doneAfterStartB", int'(doneB), 0);
        waitDoneB();
    endtask

    // Monitor A: per-cycle vector order check and end-of-sweep scoreboard compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            busyCntA = 0;
        end else begin
            if (busyA) begin
                checkOutput("sweepVecA", int'(dutInA), busyCntA / 2);
                busyCntA++;
            end
            if (doneA && !donePrevA) begin
                checkOutput("pendingA", qA.size(), 1);
                if (qA.size() > 0) begin
                    e = qA.pop_front();
                    checkOutput("passA", int'(passA), e.passExp);
                    checkOutput("errCountA", int'(errA), e.errExp);
                    if (e.errExp != 0) checkOutput("firstFailA", int'(ffvA), e.ffvExp);
                    checkOutput("lastVecA", int'(dutInA), e.lastVec);
                    checkOutput("busyCyclesA", busyCntA, e.cycles);
                end
                busyCntA = 0;
            end
        end
        donePrevA = doneA;
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            busyCntB = 0;
        end else begin
            if (busyB) begin
                checkOutput("sweepVecB", int'(dutInB), busyCntB / 3);
                busyCntB++;
            end
            if (doneB && !donePrevB) begin
                checkOutput("pendingB", qB.size(), 1);
                if (qB.size() > 0) begin
                    e = qB.pop_front();
                    checkOutput("passB", int'(passB), e.passExp);
                    checkOutput("errCountB", int'(errB), e.errExp);
                    if (e.errExp != 0) checkOutput("firstFailB", int'(ffvB), e.ffvExp);
                    checkOutput("lastVecB", int'(dutInB), e.lastVec);
                    checkOutput("busyCyclesB", busyCntB, e.cycles);
                end
                busyCntB = 0;
            end
        end
        donePrevB = doneB;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        checkOutput("rstDutInA", int'(dutInA), 0);
        checkOutput("rstBusyA", int'(busyA), 0);
        checkOutput("rstDoneA", int'(doneA), 0);
        checkOutput("rstPassA", int'(passA), 0);
        checkOutput("rstErrA", int'(errA), 0);
        checkOutput("rstFfvA", int'(ffvA), 0);
        checkOutput("rstBusyB", int'(busyB), 0);
        rst = 1'b0;

        applyStimulusA(16'h6996, 16'h0000, 1'b0);
        applyStimulusA(16'h6996, 16'h0420, 1'b0);

        @(negedge clk);
        faultA = 16'h0000;
        ttA    = 16'h6996;
        startA = 1'b1;
        @(negedge clk);
        startA = 1'b0;
        n = 0;
        while (dutInA != 4'd7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachVec7", int'(dutInA), 7);
        rst    = 1'b1;
        startA = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        startA = 1'b0;
        checkOutput("abortDutInA", int'(dutInA), 0);
        checkOutput("abortBusyA", int'(busyA), 0);
        checkOutput("abortDoneA", int'(doneA), 0);
        checkOutput("abortErrA", int'(errA), 0);
        applyStimulusA(16'h6996, 16'h0000, 1'b0);

        applyStimulusA(16'h6996, 16'h0000, 1'b1);
        applyStimulusA(16'h6996, 16'h0000, 1'b0);

        for (int i = 0; i < 6; i++) begin
            applyStimulusA(16'h6996 ^ (16'($urandom) & 16'($urandom) & 16'($urandom)),
                           16'($urandom) & 16'($urandom) & 16'($urandom), 1'b0);
        end

        applyStimulusB(4'b1000, 4'b0000);
        applyStimulusB(4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            applyStimulusB(4'($urandom), 4'($urandom) & 4'($urandom));
        end

        repeat (5) @(negedge clk);
        checkOutput("queueEmptyA", qA.size(), 0);
        checkOutput("queueEmptyB", qB.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
